// File: rtl/pe_shift_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pe_shift_acc
//  Purpose  : Multi-channel shift-accumulate stage that follows the bit-brick
//             PE array. Each accepted beat carries NCH partial sums, each with
//             its own shift select. Every sum is sign- or zero-extended,
//             shifted left by sel*SHIFT_STEP and added into one beat sum. Beat
//             sums are accumulated over a variable-length burst that ends on
//             in_last. The result is then held on a valid/ready output
//             together with the burst length and an overflow flag.
//
//  Ports    : clk          - clock, rising edge
//             reset        - asynchronous, active-high reset
//             in_valid     - input beat valid
//             in_ready     - block can accept a beat (low while a result is held)
//             in_last      - final beat of the burst
//             signed_mode  - 1 = sign-extend channels, 0 = zero-extend
//             psum_in      - NCH partial sums, channel i at [i*IN_W +: IN_W]
//             shift_sel    - NCH shift selects, channel i at [i*SEL_W +: SEL_W]
//             out_valid    - result valid
//             out_ready    - downstream accepts the result
//             acc_out      - low OUT_W bits of the accumulator
//             out_beats    - beats in the burst, saturating at 2^CNT_W-1
//             overflow     - result did not fit OUT_W (mode of the last beat)
//
//  Revision : 1.0 - initial release
// ============================================================================
module pe_shift_acc #(
    parameter int NCH        = 4,
    parameter int IN_W       = 8,
    parameter int SEL_W      = 3,
    parameter int SHIFT_STEP = 2,
    parameter int OUT_W      = 20,
    parameter int GUARD      = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic                   signed_mode,
    input  logic [NCH*IN_W-1:0]    psum_in,
    input  logic [NCH*SEL_W-1:0]   shift_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       acc_out,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   overflow
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_ACC_W    = OUT_W + GUARD;
    // Largest shift any channel can request; the shift-amount bus is sized
    // so that the product sel*SHIFT_STEP never truncates.
    localparam int c_MAX_SH   = ((2 ** SEL_W) - 1) * SHIFT_STEP;
    localparam int c_SHAMT_W  = (c_MAX_SH > 0) ? $clog2(c_MAX_SH + 1) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_acc_out;
    logic [CNT_W-1:0]    r_beats_out;
    logic                r_ovf;

    // ------------------------------------------------------------------------
    // Per-channel extend and shift
    // ------------------------------------------------------------------------
    logic [c_ACC_W-1:0]  w_term [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [IN_W-1:0]      w_psum;
        logic [SEL_W-1:0]     w_sel;
        logic [c_SHAMT_W-1:0] w_shamt;
        logic [c_ACC_W-1:0]   w_ext;

        assign w_psum  = psum_in[gi*IN_W +: IN_W];
        assign w_sel   = shift_sel[gi*SEL_W +: SEL_W];
        assign w_shamt = c_SHAMT_W'(w_sel) * c_SHAMT_W'(SHIFT_STEP);

        // Extension happens at full accumulator width before the shift, so
        // negative channels keep their sign across the whole shifted term.
        assign w_ext = signed_mode
                     ? {{(c_ACC_W-IN_W){w_psum[IN_W-1]}}, w_psum}
                     : {{(c_ACC_W-IN_W){1'b0}},           w_psum};

        // Bits pushed beyond the accumulator width are simply dropped.
        assign w_term[gi] = w_ext << w_shamt;
    end : g_ch

    // ------------------------------------------------------------------------
    // Beat sum (modulo 2^c_ACC_W)
    // ------------------------------------------------------------------------
    logic [c_ACC_W-1:0] w_beat_sum;

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            w_beat_sum = w_beat_sum + w_term[i];
        end
    end

    // ------------------------------------------------------------------------
    // Next accumulator / counter values for an accepted beat
    // ------------------------------------------------------------------------
    logic               w_accept;
    logic               w_first;
    logic [c_ACC_W-1:0] w_acc_base;
    logic [c_ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;

    assign in_ready  = (r_state != c_HOLD);
    assign out_valid = (r_state == c_HOLD);
    assign w_accept  = in_valid & in_ready;

    // A beat taken in IDLE starts a fresh burst regardless of what is left
    // in the accumulator register.
    assign w_first    = (r_state == c_IDLE);
    assign w_acc_base = w_first ? '0 : r_acc;
    assign w_acc_next = w_acc_base + w_beat_sum;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_first) begin
            w_cnt_next = CNT_W'(1);
        end else if (!(&r_cnt)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Overflow detection on the value about to be presented
    // ------------------------------------------------------------------------
    // Signed: everything from bit OUT_W-1 upward must be a copy of the sign
    // bit for the value to fit. Unsigned: nothing may be set at or above
    // OUT_W. Wrap inside the accumulator itself is not visible here.
    logic [c_ACC_W-OUT_W:0]   w_upper_s;
    logic [c_ACC_W-OUT_W-1:0] w_upper_u;
    logic                     w_ovf_s;
    logic                     w_ovf_u;
    logic                     w_ovf;

    assign w_upper_s = w_acc_next[c_ACC_W-1:OUT_W-1];
    assign w_upper_u = w_acc_next[c_ACC_W-1:OUT_W];
    assign w_ovf_s   = ~((&w_upper_s) | ~(|w_upper_s));
    assign w_ovf_u   = |w_upper_u;
    assign w_ovf     = signed_mode ? w_ovf_s : w_ovf_u;

    // ------------------------------------------------------------------------
    // Control FSM and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_out   <= '0;
            r_beats_out <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (in_last) begin
                            // Result registers are loaded only here, so they
                            // stay frozen for the whole hold period.
                            r_state     <= c_HOLD;
                            r_acc_out   <= w_acc_next[OUT_W-1:0];
                            r_beats_out <= w_cnt_next;
                            r_ovf       <= w_ovf;
                        end else begin
                            r_state <= c_ACC;
                        end
                    end
                end
                c_HOLD: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign acc_out   = r_acc_out;
    assign out_beats = r_beats_out;
    assign overflow  = r_ovf;

endmodule : pe_shift_acc
`default_nettype wire

// File: tb/tb_pe_shift_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pe_shift_acc
//  Purpose  : Self-checking bench for pe_shift_acc. Stimulus pushes expected
//             results into a scoreboard queue; a monitor pops and compares on
//             every output handshake. Directed cases cover the documented
//             examples; a randomized phase runs bursts under random
//             backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_shift_acc;

    localparam int NCH        = 4;
    localparam int IN_W       = 8;
    localparam int SEL_W      = 3;
    localparam int SHIFT_STEP = 2;
    localparam int OUT_W      = 20;
    localparam int GUARD      = 4;
    localparam int CNT_W      = 8;
    localparam int A_W        = OUT_W + GUARD;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_last = 1'b0;
    logic                 signed_mode = 1'b0;
    logic [NCH*IN_W-1:0]  psum_in = '0;
    logic [NCH*SEL_W-1:0] shift_sel = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OUT_W-1:0]     acc_out;
    logic [CNT_W-1:0]     out_beats;
    logic                 overflow;

    pe_shift_acc #(
        .NCH(NCH), .IN_W(IN_W), .SEL_W(SEL_W), .SHIFT_STEP(SHIFT_STEP),
        .OUT_W(OUT_W), .GUARD(GUARD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .signed_mode(signed_mode), .psum_in(psum_in), .shift_sel(shift_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .out_beats(out_beats), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Counters and scoreboard
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [OUT_W-1:0] acc;
        logic [CNT_W-1:0] beats;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: plain integer arithmetic
    // ------------------------------------------------------------------------
    localparam longint MOD_A = longint'(1) << A_W;

    longint m_acc = 0;
    int     m_cnt = 0;

    function automatic longint beat_value(input logic [NCH*IN_W-1:0] ps,
                                          input logic [NCH*SEL_W-1:0] sl,
                                          input bit sm);
        longint s = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            int     raw = int'(ps[ch*IN_W +: IN_W]);
            int     sh  = int'(sl[ch*SEL_W +: SEL_W]) * SHIFT_STEP;
            longint v   = (sm && raw >= (1 << (IN_W-1))) ? longint'(raw - (1 << IN_W)) : longint'(raw);
            s = s + v * (longint'(1) << sh);
        end
        return s;
    endfunction

    function automatic longint wrap_a(input longint x);
        return x & (MOD_A - 1);
    endfunction

    function automatic bit ovf_of(input longint acc, input bit sm);
        longint sv = (acc >= (MOD_A / 2)) ? acc - MOD_A : acc;
        if (sm) return (sv < -(longint'(1) << (OUT_W-1))) || (sv > (longint'(1) << (OUT_W-1)) - 1);
        return acc >= (longint'(1) << OUT_W);
    endfunction

    // ------------------------------------------------------------------------
    // out_ready driver: either forced level or random per cycle
    // ------------------------------------------------------------------------
    bit rand_rdy  = 1'b0;
    bit rdy_force = 1'b1;

    always begin
        @(posedge clk);
        #2;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // ------------------------------------------------------------------------
    // Monitor: a handshake happens at the next rising edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: result 0x%0h presented, none expected", acc_out);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_acc_out",   longint'(acc_out),   longint'(mon_e.acc));
                chk("sb_out_beats", longint'(out_beats), longint'(mon_e.beats));
                chk("sb_overflow",  longint'(overflow),  longint'(mon_e.ovf));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic send_beat(input logic [NCH*IN_W-1:0] ps,
                             input logic [NCH*SEL_W-1:0] sl,
                             input bit sm, input bit last);
        bit     ok = 1'b0;
        logic   rd;
        longint bv;
        exp_t   e;
        psum_in     = ps;
        shift_sel   = sl;
        signed_mode = sm;
        in_last     = last;
        in_valid    = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            rd = in_ready;
            @(posedge clk);
            #1;
            if (rd) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept_timeout: in_ready stayed 0, expected 1 within 60 cycles");
        end else begin
            bv    = beat_value(ps, sl, sm);
            m_acc = (m_cnt == 0) ? wrap_a(bv) : wrap_a(m_acc + bv);
            m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
            if (last) begin
                e.acc   = m_acc[OUT_W-1:0];
                e.beats = m_cnt[CNT_W-1:0];
                e.ovf   = ovf_of(m_acc, sm);
                sb.push_back(e);
                m_acc = 0;
                m_cnt = 0;
            end
        end
    endtask

    // Called right after the last beat is taken: result must already be up.
    task automatic check_held(input string name, input longint acc,
                              input longint beats, input longint ovf);
        chk({name, "_out_valid"}, longint'(out_valid), 1);
        chk({name, "_acc_out"},   longint'(acc_out),   acc);
        chk({name, "_out_beats"}, longint'(out_beats), beats);
        chk({name, "_overflow"},  longint'(overflow),  ovf);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int   g;
        bit   done;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_acc_out",   longint'(acc_out),   0);
        chk("rst_out_beats", longint'(out_beats), 0);
        chk("rst_overflow",  longint'(overflow),  0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        idle(1);

        // Single signed beat: 5 - 4 - 2048 + 64 = -1983
        send_beat(32'h01_80_FF_05, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1, 1'b1);
        check_held("single_signed", 20'hFF841, 1, 0);

        // Same beat unsigned: 5 + 1020 + 2048 + 64 = 3137
        send_beat(32'h01_80_FF_05, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 1'b1);
        check_held("single_unsigned", 20'h00C41, 1, 0);

        // Three beats of 1<<12 with 0, 1, 2 idle cycles between them
        for (int b = 0; b < 3; b++) begin
            send_beat(32'h0000_0001, 12'h006, 1'b1, b == 2);
            if (b < 2) idle(b);
        end
        check_held("three_beat", 20'h03000, 3, 0);

        // Backpressure: result held while in_valid is driven
        idle(2);
        rdy_force = 1'b0;
        idle(2);
        send_beat(32'h0000_0003, 12'h000, 1'b1, 1'b1);
        in_valid = 1'b1;
        psum_in  = 32'h7F7F_7F7F;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready",  longint'(in_ready),  0);
            chk("bp_acc_out",   longint'(acc_out),   3);
            chk("bp_overflow",  longint'(overflow),  0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("bp_release_done", longint'(done), 1);
        chk("bp_in_ready_after", longint'(in_ready), 1);
        chk("bp_sb_drained", longint'(sb.size()), 0);
        idle(1);

        // Signed overflow: 0x7F000 + 0x7F000 = 0xFE000
        send_beat(32'h0000_007F, 12'h006, 1'b1, 1'b0);
        send_beat(32'h0000_007F, 12'h006, 1'b1, 1'b1);
        check_held("ovf", 20'hFE000, 2, 1);
        send_beat(32'h0000_0001, 12'h000, 1'b1, 1'b1);
        check_held("ovf_clear", 20'h00001, 1, 0);

        // Asynchronous reset mid-burst
        idle(2);
        send_beat(32'h0000_0010, 12'h000, 1'b1, 1'b0);
        send_beat(32'h0000_0010, 12'h000, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_acc_out",   longint'(acc_out),   0);
        chk("arst_out_beats", longint'(out_beats), 0);
        chk("arst_overflow",  longint'(overflow),  0);
        #2;
        reset = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        chk("arst_in_ready", longint'(in_ready), 1);
        idle(1);
        send_beat(32'h0000_0002, 12'h000, 1'b1, 1'b1);
        check_held("post_rst", 20'h00002, 1, 0);

        // Beat counter saturation: 300 beats of +1
        for (int b = 0; b < 300; b++) begin
            send_beat(32'h0000_0001, 12'h000, 1'b0, b == 299);
        end
        check_held("sat", 300, 255, 0);

        // Randomized bursts under random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                send_beat($urandom, 12'($urandom_range(0, 4095)),
                          1'($urandom_range(0, 1)), b == len - 1);
                g = int'($urandom_range(0, 2));
                if (g > 0) idle(g);
            end
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;

        // Drain
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("final_drain", longint'(done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pe_shift_acc
`default_nettype wire
